fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Sequential instruction-fetch front end for the MIPS core.
- Owns the PC register and fetches each instruction from a variable-latency instruction memory over a request/response handshake.
- Presents the current PC and instruction to the next-PC logic and the datapath.
- Loads the next-PC result back into the PC when the instruction retires.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, value driven on instr while no valid instruction is held.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- imem_req  output  1  fetch request valid
- imem_addr  output  32  fetch byte address; equals pc
- imem_ready  input  1  memory accepts request this cycle
- imem_rvalid  input  1  fetch data valid
- imem_rdata  input  32  fetched instruction word
- pc  output  32  address of the held/fetching instruction (next-PC logic "old" input)
- instr  output  32  held instruction (next-PC logic / decode input)
- instr_valid  output  1  instr is valid and executing this cycle
- stall  input  1  datapath cannot retire the held instruction this cycle
- next_pc_in  input  32  next-PC result computed from pc/instr/Branch/zero/Jump
- fault  output  1  misaligned next PC detected; sticky until reset
- retire_count  output  32  number of retired instructions

Behaviour:
- Reset (synchronous, active-high): pc=RESET_PC; state=FETCH; instr=NOP_INSTR; instr_valid=0; fault=0; retire_count=0. imem_req is combinational and is 1 in the first cycle after reset deasserts.
- Reset mid-operation (any state, including WAIT) aborts the fetch immediately. The memory shares the same reset, so no stale response is delivered afterward.
- State FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_ready=1 -> WAIT. Otherwise hold the request with a stable address.
  - imem_rvalid is ignored in FETCH.
- State WAIT:
  - imem_req=0.
  - imem_rvalid=1 -> latch imem_rdata into instr, set instr_valid=1, go to EXEC.
  - Otherwise remain in WAIT; there is no timeout.
- State EXEC:
  - instr_valid=1; pc and instr are stable.
  - If stall=1, hold everything.
  - If stall=0, the instruction retires this cycle:
    - retire_count += 1 (wraps 0xFFFF_FFFF -> 0).
    - instr_valid->0, instr->NOP_INSTR.
    - If next_pc_in[1:0]==0: pc<=next_pc_in, go to FETCH.
    - Else: fault<=1, pc unchanged, go to HALT.
- State HALT:
  - imem_req=0, instr_valid=0; terminal until reset.
  - retire_count frozen (the faulting instruction still counts as retired).
- Exactly one outstanding request at a time.
- Minimum cost is 3 cycles per instruction: accept, response, retire.
- imem_rvalid asserted in any state other than WAIT is ignored.
- next_pc_in is sampled only in the EXEC retire cycle, so it may be combinationally derived from pc/instr.
- Encode FETCH/WAIT/EXEC/HALT in 2 bits; there are no unreachable-state hazards.
- PC arithmetic is external; this block does no addition.
- pc wrap-around (0xFFFF_FFFC+4 -> 0) is accepted as a legal aligned value.

Test Plan:
1. Reset then zero-wait memory (imem_ready=1, rvalid the cycle after accept), next_pc_in=pc+4, stall=0 -> pc sequence 0x0,0x4,0x8, one retire every 3 cycles, retire_count=3 after 9 cycles post-reset.
2. imem_ready low for 4 cycles, then rvalid delayed 5 cycles -> imem_addr stays 0x0 throughout, instr_valid rises exactly the cycle after rvalid, instr=imem_rdata (e.g. 0x2008_0005).
3. stall=1 for 3 cycles in EXEC -> pc, instr, instr_valid and retire_count unchanged; retire happens on the first stall=0 cycle.
4. Branch/jump: next_pc_in=0x0000_0040 at retire of pc=0x8 -> next imem_addr=0x40 with no intervening fetch of 0xC.
5. next_pc_in=0x0000_0042 -> fault=1, state HALT, imem_req=0, pc stays at faulting address, retire_count incremented once then frozen; reset clears fault and restarts at RESET_PC.
6. Spurious rvalid in FETCH/EXEC is ignored. Reset asserted during WAIT -> next cycle pc=RESET_PC, instr_valid=0, imem_req=1.

Source files
------------

// File: rtl/fetch_unit.sv
// Sequential instruction-fetch front end: owns the PC, fetches one instruction
// at a time over a req/ready + rvalid handshake and retires it into next_pc_in.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic [31:0] next_pc_in,
  output logic        fault,
  output logic [31:0] retire_count
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t state;

  // Request is decoded straight from the state register so it is high in the
  // very first cycle after reset releases.
  always_comb begin
    imem_req  = (state == S_FETCH);
    imem_addr = pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_FETCH;
      pc           <= RESET_PC;
      instr        <= NOP_INSTR;
      instr_valid  <= 1'b0;
      fault        <= 1'b0;
      retire_count <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            retire_count <= retire_count + 32'd1;
            instr_valid  <= 1'b0;
            instr        <= NOP_INSTR;
            if (next_pc_in[1:0] == 2'b00) begin
              pc    <= next_pc_in;
              state <= S_FETCH;
            end else begin
              fault <= 1'b1;
              state <= S_HALT;
            end
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule
